// File: rtl/disp_pkg.sv
// Shared definitions for the display path: digit count, decimal ceiling,
// BCD nibble type and the converter state encoding.
package disp_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_DEC    = 9999;

    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// shift, so that the shift carries cleanly into the next decade.
module bcd_digit_adj
    import disp_pkg::*;
(
    input  bcd_t din,
    output bcd_t dout
);
    assign dout = (din >= 4'd5) ? bcd_t'(din + 4'd3) : din;
endmodule

// File: rtl/bin_to_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock,
// with a stable registered 4-digit result for the seven-segment scanner.
module bin_to_bcd_conv
    import disp_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] in_bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      disps,
    output logic             done,
    output logic             ovf
);
    localparam int CNT_W = $clog2(BIN_W);

    conv_state_t          state_p0;
    logic [BIN_W-1:0]     bin_p0;
    logic [15:0]          bcd_p0;
    logic [CNT_W-1:0]     cnt_p0;
    logic                 ovf_pend_p0;
    logic [15:0]          adj;
    logic [15:0]          bcd_next;

    // Constant-false for BIN_W < 14, leaving ovf permanently low.
    function automatic logic is_ovf(input logic [BIN_W-1:0] v);
        return 32'(v) > 32'(MAX_DEC);
    endfunction

    function automatic logic [BIN_W-1:0] sat_dec(input logic [BIN_W-1:0] v);
        return is_ovf(v) ? BIN_W'(MAX_DEC) : v;
    endfunction

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (bcd_p0[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign bcd_next = {adj[14:0], bin_p0[BIN_W-1]};
    assign in_ready = (state_p0 == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0    <= IDLE;
            bin_p0      <= '0;
            bcd_p0      <= '0;
            cnt_p0      <= '0;
            ovf_pend_p0 <= 1'b0;
            disps       <= 16'h0000;
            done        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_p0)
                IDLE: begin
                    if (in_valid) begin
                        bin_p0      <= sat_dec(in_bin);
                        ovf_pend_p0 <= is_ovf(in_bin);
                        bcd_p0      <= '0;
                        cnt_p0      <= '0;
                        state_p0    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_p0 <= bcd_next;
                    bin_p0 <= bin_p0 << 1;
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                    // Final bit: publish result and return to IDLE together.
                    if (cnt_p0 == CNT_W'(BIN_W - 1)) begin
                        disps    <= bcd_next;
                        ovf      <= ovf_pend_p0;
                        done     <= 1'b1;
                        state_p0 <= IDLE;
                    end
                end
                default: state_p0 <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Scoreboard bench for bin_to_bcd_conv: requests push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_bin_to_bcd_conv;
    localparam int BIN_W = 14;
    localparam int LAT   = 14;

    typedef struct {
        logic [15:0] disps;
        logic        ovf;
        int          acc_cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [BIN_W-1:0] in_bin;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      disps;
    logic             done;
    logic             ovf;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   n_done  = 0;
    int   n_exp   = 0;
    int   cyc     = 0;
    logic prev_done = 1'b0;

    bin_to_bcd_conv #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bin   (in_bin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .disps    (disps),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("disps", {16'd0, disps}, {16'd0, e.disps});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                chk("latency", cyc - e.acc_cyc, LAT);
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [BIN_W-1:0] v, input logic [15:0] exp_d, input logic exp_o);
        exp_t e;
        wait_ready();
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.disps   = exp_d;
        e.ovf     = exp_o;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        n_exp++;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bin   = '0;

        // Reset held for two clocks.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_disps", {16'd0, disps}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        send(14'd1234, 16'h1234, 1'b0);
        drain();
        chk("done_low_after", {31'd0, done}, 32'd0);

        send(14'd0, 16'h0000, 1'b0);
        send(14'd9999, 16'h9999, 1'b0);
        send(14'd9, 16'h0009, 1'b0);
        drain();

        send(14'd12000, 16'h9999, 1'b1);
        send(14'd10000, 16'h9999, 1'b1);
        send(14'd42, 16'h0042, 1'b0);
        drain();

        // Request while busy is dropped.
        send(14'd5678, 16'h5678, 1'b0);
        repeat (2) @(negedge clk);
        chk("busy_not_ready", {31'd0, in_ready}, 32'd0);
        in_bin   = 14'd1111;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("disps_hold", {16'd0, disps}, 32'h5678);
        chk("done_count", n_done, n_exp);

        // Reset mid-conversion aborts without a done pulse.
        wait_ready();
        in_bin   = 14'd4321;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_disps", {16'd0, disps}, 32'h0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        repeat (20) @(negedge clk);
        chk("abort_no_done", n_done, n_exp);
        chk("abort_disps_hold", {16'd0, disps}, 32'h0);

        send(14'd4321, 16'h4321, 1'b0);
        drain();
        chk("final_done_count", n_done, n_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
